conv_result_streamer: RTL and testbench

//  Downstream stage of the 3x3 convolution engine. Captures each 8-bit result

---
 rtl/conv_result_streamer_if.sv | 26 ++
 rtl/conv_result_streamer.sv | 165 ++++++++++++++++
 tb/tb_conv_result_streamer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_result_streamer_if.sv
// Pixel-stream bus between the conv engine result strobe, the streamer and its consumer.
// master drives the capture inputs and out_ready; slave is the streamer itself.
interface conv_result_streamer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  done_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  bin_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_eol;
  logic                  out_eof;
  logic                  overflow;
  logic                  frame_done;

  modport master (
    output done_in, data_in, bin_en, out_ready,
    input  out_valid, out_data, out_eol, out_eof, overflow, frame_done
  );

  modport slave (
    input  done_in, data_in, bin_en, out_ready,
    output out_valid, out_data, out_eol, out_eof, overflow, frame_done
  );
endinterface

// File: rtl/conv_result_streamer.sv
// Captures conv engine results, optionally binarises them, tags row/frame ends and
// streams them out of a small first-word-fall-through FIFO with valid/ready.
module conv_result_streamer #(
  parameter int unsigned IMG_W      = 510,
  parameter int unsigned IMG_H      = 510,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned THRESH     = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  conv_result_streamer_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [DATA_WIDTH-1:0] L_THRESH = DATA_WIDTH'(THRESH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  eol;
    logic                  eof;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_capture_en;
  logic                 w_frame_done;

  logic [COL_W-1:0]     r_col;
  logic [ROW_W-1:0]     r_row;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_overflow;
  entry_t               r_mem [FIFO_DEPTH];

  logic                 w_capture;
  logic                 w_eol;
  logic                 w_eof;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [DATA_WIDTH-1:0] w_pix;
  entry_t               w_head;

  // Position tags and capture qualification
  assign w_capture = bus.done_in && w_capture_en;
  assign w_eol     = (r_col == COL_W'(IMG_W - 1));
  assign w_eof     = w_eol && (r_row == ROW_W'(IMG_H - 1));
  assign w_pix     = bus.bin_en ? ((bus.data_in >= L_THRESH) ? '1 : '0) : bus.data_in;

  // FIFO handshake; a pop frees the slot a same-cycle push needs when full
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && bus.out_ready;
  assign w_push  = w_capture && (!w_full || w_pop);
  assign w_drop  = bus.done_in && !w_push;
  assign w_head  = r_mem[r_rd_ptr];

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_RUN: begin
        if (w_capture) begin
          w_state_next = w_eof ? S_DRAIN : S_RUN;
        end
      end
      S_DRAIN: begin
        if (w_empty) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_capture_en = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE, S_RUN: w_capture_en = 1'b1;
      S_DONE:        w_frame_done = 1'b1;
      default: ;
    endcase
  end

  // Row/column tracking; advances on every capture attempt, dropped or not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_capture) begin
      if (w_eol) begin
        r_col <= '0;
        r_row <= w_eof ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are masked at the outputs while empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{data: w_pix, eol: w_eol, eof: w_eof};
    end
  end

  assign bus.out_valid  = !w_empty;
  assign bus.out_data   = w_empty ? '0 : w_head.data;
  assign bus.out_eol    = !w_empty && w_head.eol;
  assign bus.out_eof    = !w_empty && w_head.eof;
  assign bus.overflow   = r_overflow;
  assign bus.frame_done = w_frame_done;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed and randomized checks of conv_result_streamer against a queue-based
// reference model of pixel position, FIFO contents and frame completion.
module tb_conv_result_streamer;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int D   = 4;
  localparam int THR = 128;

  typedef struct packed {
    logic [7:0] d;
    logic       eol;
    logic       eof;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_result_streamer_if #(.DATA_WIDTH(8)) bus();

  conv_result_streamer #(
    .IMG_W(W), .IMG_H(H), .DATA_WIDTH(8), .FIFO_DEPTH(D), .THRESH(THR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: pixel index within frame, expected FIFO contents,
  // frame phase (0 capturing, 1 waiting for drain, 2 frame_done cycle)
  pix_t q[$];
  pix_t popped[$];
  int   pix;
  int   phase;
  logic m_ovf;
  int   fd_count;
  int   n_tests;
  int   n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_data", 32'(bus.out_data), 32'(q[0].d));
      check("out_eol",  32'(bus.out_eol),  32'(q[0].eol));
      check("out_eof",  32'(bus.out_eof),  32'(q[0].eof));
    end else begin
      check("idle_data", 32'(bus.out_data), 32'd0);
      check("idle_eol",  32'(bus.out_eol),  32'd0);
      check("idle_eof",  32'(bus.out_eof),  32'd0);
    end
    check("overflow",   32'(bus.overflow),   32'(m_ovf));
    check("frame_done", 32'(bus.frame_done), 32'(phase == 2));
    if (bus.frame_done) fd_count++;
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge
  task automatic step(input logic d, input logic [7:0] v, input logic b, input logic r);
    pix_t e;
    bit   pop;
    bit   push;
    int   nphase;
    bus.done_in   = d;
    bus.data_in   = v;
    bus.bin_en    = b;
    bus.out_ready = r;
    if (bus.out_valid && r) popped.push_back('{bus.out_data, bus.out_eol, bus.out_eof});
    e      = '0;
    pop    = (q.size() != 0) && r;
    push   = 1'b0;
    nphase = phase;
    if (phase == 2) nphase = 0;
    else if (phase == 1 && q.size() == 0) nphase = 2;
    if (d && phase == 0) begin
      e.d   = b ? ((int'(v) >= THR) ? 8'hFF : 8'h00) : v;
      e.eol = ((pix % W) == W - 1);
      e.eof = (pix == W * H - 1);
      if (q.size() < D || pop) push = 1'b1;
      else m_ovf = 1'b1;
      pix = (pix + 1) % (W * H);
      if (e.eof) nphase = 1;
    end else if (d) begin
      m_ovf = 1'b1;
    end
    phase = nphase;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, r);
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid),  32'd0);
    check({tag, "_data"},  32'(bus.out_data),   32'd0);
    check({tag, "_eol"},   32'(bus.out_eol),    32'd0);
    check({tag, "_eof"},   32'(bus.out_eof),    32'd0);
    check({tag, "_ovf"},   32'(bus.overflow),   32'd0);
    check({tag, "_fd"},    32'(bus.frame_done), 32'd0);
  endtask

  task automatic do_reset();
    bus.done_in   = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_zero("rst_hold");
    q.delete();
    pix   = 0;
    phase = 0;
    m_ovf = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    fd_count = 0;
    pix      = 0;
    phase    = 0;
    m_ovf    = 1'b0;
    bus.done_in   = 1'b0;
    bus.data_in   = 8'h00;
    bus.bin_en    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3, 1'b1);

    // 1: reset while idle
    do_reset();

    // 2: one spaced-out raw frame
    popped.delete();
    fd_count = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
      idle(8, 1'b1);
    end
    check("t2_pop_count", 32'(popped.size()), 32'd8);
    for (int i = 0; i < popped.size(); i++) begin
      check("t2_data", 32'(popped[i].d),   32'(8'h10 + i));
      check("t2_eol",  32'(popped[i].eol), 32'((i % 4) == 3));
      check("t2_eof",  32'(popped[i].eof), 32'(i == 7));
    end
    check("t2_frame_done_pulses", 32'(fd_count), 32'd1);
    check("t2_overflow", 32'(bus.overflow), 32'd0);

    // 3: stalled consumer, fifth back-to-back result dropped
    popped.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    check("t3_overflow", 32'(bus.overflow), 32'd1);
    idle(6, 1'b1);
    check("t3_pop_count", 32'(popped.size()), 32'd4);
    for (int i = 0; i < popped.size(); i++)
      check("t3_data", 32'(popped[i].d), 32'(8'hA0 + i));

    // 4: binarisation, continuing the frame from column 1 of row 1
    popped.delete();
    step(1'b1, 8'd127, 1'b1, 1'b1);
    check("t4_col1_eol", 32'(bus.out_eol), 32'd0);
    idle(2, 1'b1);
    step(1'b1, 8'd128, 1'b1, 1'b1);
    idle(2, 1'b1);
    step(1'b1, 8'd255, 1'b1, 1'b1);
    check("t4_eof_tag", 32'(bus.out_eof), 32'd1);
    idle(6, 1'b1);
    step(1'b1, 8'd0, 1'b1, 1'b1);
    idle(3, 1'b1);
    check("t4_pop_count", 32'(popped.size()), 32'd4);
    if (popped.size() == 4) begin
      check("t4_bin0", 32'(popped[0].d), 32'h00);
      check("t4_bin1", 32'(popped[1].d), 32'hFF);
      check("t4_bin2", 32'(popped[2].d), 32'hFF);
      check("t4_bin3", 32'(popped[3].d), 32'h00);
    end

    // 5: push and pop in the same cycle on a full FIFO
    do_reset();
    popped.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    step(1'b1, 8'h54, 1'b0, 1'b1);
    check("t5_no_drop", 32'(bus.overflow), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("t5_still_valid", 32'(bus.out_valid), 32'd1);
    idle(6, 1'b1);
    check("t5_pop_count", 32'(popped.size()), 32'd5);
    for (int i = 0; i < popped.size(); i++)
      check("t5_data", 32'(popped[i].d), 32'(8'h50 + i));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'(8'h58 + i), 1'b0, 1'b1);
      idle(2, 1'b1);
    end
    idle(5, 1'b1);
    check("t5_overflow_end", 32'(bus.overflow), 32'd0);

    // 6: reset mid-frame, then a clean back-to-back frame
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'(8'h60 + i), 1'b0, 1'b1);
      idle(1, 1'b1);
    end
    do_reset();
    popped.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b1);
    idle(6, 1'b1);
    check("t6_pop_count", 32'(popped.size()), 32'd8);
    for (int i = 0; i < popped.size(); i++) begin
      check("t6_data", 32'(popped[i].d),   32'(8'h70 + i));
      check("t6_eol",  32'(popped[i].eol), 32'((i % 4) == 3));
      check("t6_eof",  32'(popped[i].eof), 32'(i == 7));
    end

    // Randomized traffic, including drops and protocol-error strobes
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));
    end
    idle(10, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
